// File: rtl/mux64_sched_pkg.sv
// Shared constants, FSM state type and counter-width helper for the
// mux64_rr_sched round-robin scheduler.
package mux64_sched_pkg;

    localparam int N_REQ  = 64;
    localparam int SEL_W  = 6;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        WAIT,
        HOLD
    } sched_state_e;

    // Width needed to hold MUX_LAT as a down-counter start value, never below 1.
    function automatic int cnt_width(input int lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_pick64.sv
// Combinational rotate-find-first: returns the first set bit of vec_i found
// searching upward from ptr_i+1 (mod 64); ptr_i itself is checked last.
module rr_pick64
    import mux64_sched_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr_i + SEL_W'(i);
            if (vec_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux64_rr_sched.sv
// Round-robin scheduler owning the select of a shared 64:1 byte mux.
// Arbitrates req, drives sel, waits MUX_LAT cycles, captures mux_out and
// presents it with its source index on a valid/ready port.
// Optional feature macro: MUX64_SCHED_PRIO_EN (adds a prio[63:0] input that
// restricts round-robin to req & prio whenever that is nonzero).
module mux64_rr_sched
    import mux64_sched_pkg::*;
#(
    parameter int MUX_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
`ifdef MUX64_SCHED_PRIO_EN
    input  logic [N_REQ-1:0]  prio,
`endif
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_id,
    output logic [N_REQ-1:0]  gnt,
    output logic              busy
);

    localparam int CNT_W = cnt_width(MUX_LAT);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic              win_found;
    logic [SEL_W-1:0]  win_idx;

`ifdef MUX64_SCHED_PRIO_EN
    logic [N_REQ-1:0]  req_hi;
    logic              found_hi, found_all;
    logic [SEL_W-1:0]  idx_hi, idx_all;

    assign req_hi = req & prio;

    rr_pick64 u_pick_hi (
        .vec_i   (req_hi),
        .ptr_i   (ptr_q),
        .found_o (found_hi),
        .idx_o   (idx_hi)
    );

    rr_pick64 u_pick_all (
        .vec_i   (req),
        .ptr_i   (ptr_q),
        .found_o (found_all),
        .idx_o   (idx_all)
    );

    // Priority class wins whenever any prioritised requester is pending;
    // both classes advance the same pointer.
    always_comb begin
        win_found = found_all;
        win_idx   = idx_all;
        if (|req_hi) begin
            win_found = found_hi;
            win_idx   = idx_hi;
        end
    end
`else
    rr_pick64 u_pick (
        .vec_i   (req),
        .ptr_i   (ptr_q),
        .found_o (win_found),
        .idx_o   (win_idx)
    );
`endif

    // State register; reset parks the pointer at 63 so the first search starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '1;
            sel_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and grant logic; sel only moves on the ARB->WAIT edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        id_d    = id_q;
        data_d  = data_q;
        valid_d = valid_q;
        gnt     = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) state_d = ARB;
            end
            ARB: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    id_d    = win_idx;
                    cnt_d   = CNT_W'(MUX_LAT);
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    data_d  = mux_out;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // A reset in the same cycle aborts the transaction without a grant.
                if (out_ready && !rst) begin
                    gnt[id_q] = 1'b1;
                    ptr_d     = id_q;
                    valid_d   = 1'b0;
                    state_d   = ARB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux64_rr_sched.sv
// Scoreboarded bench for mux64_rr_sched: a transaction-level round-robin
// model predicts grant order and captured bytes; a monitor checks every
// accepted transfer and the grant bus each cycle. A second instance with
// MUX_LAT=2 and a garbage-producing mux model checks capture timing.
module tb_mux64_rr_sched;

    typedef struct packed {
        logic [5:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req;
    logic [5:0]  sel;
    logic [7:0]  mux_out;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [5:0]  out_id;
    logic [63:0] gnt;
    logic        busy;
    logic        mux_noise;
    logic [7:0]  noise;

    logic [63:0] req1;
    logic [5:0]  sel1;
    logic [7:0]  mux_out1;
    logic        valid1;
    logic        ready1 = 1'b1;
    logic [7:0]  data1;
    logic [5:0]  id1;
    logic [63:0] gnt1;
    logic        busy1;
    logic [5:0]  p1_sel, p2_sel;
    logic [7:0]  garb;

    logic [63:0] prio;
    logic [63:0] prio1 = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mptr = 63;
    exp_t exp_q[$];
    int   acc_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational mux tree model: in[k] = k + 8'hA0, optionally corrupted.
    assign mux_out = ({2'b00, sel} + 8'hA0) ^ (mux_noise ? noise : 8'h00);

    // Two-stage registered tree model: garbage until sel has been stable two cycles.
    always @(posedge clk) begin
        p1_sel <= sel1;
        p2_sel <= p1_sel;
        garb   <= 8'($urandom);
    end
    assign mux_out1 = (p1_sel == sel1 && p2_sel == sel1) ? ({2'b00, sel1} + 8'hA0)
                                                         : (({2'b00, sel1} + 8'hA0) ^ {garb[7:1], 1'b1});

    mux64_rr_sched #(.MUX_LAT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef MUX64_SCHED_PRIO_EN
        .prio      (prio),
`endif
        .sel       (sel),
        .mux_out   (mux_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .gnt       (gnt),
        .busy      (busy)
    );

    mux64_rr_sched #(.MUX_LAT(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
`ifdef MUX64_SCHED_PRIO_EN
        .prio      (prio1),
`endif
        .sel       (sel1),
        .mux_out   (mux_out1),
        .out_valid (valid1),
        .out_ready (ready1),
        .out_data  (data1),
        .out_id    (id1),
        .gnt       (gnt1),
        .busy      (busy1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference round-robin: first set bit strictly after p, wrapping, p itself last.
    function automatic int rr_pick(input logic [63:0] v, input int p);
        for (int d = 1; d <= 64; d++)
            if (v[(p + d) % 64]) return (p + d) % 64;
        return -1;
    endfunction

    // Predict the full service order of a batch raised while idle, then raise it.
    task automatic issue(input logic [63:0] set, input logic [63:0] pr);
        logic [63:0] s;
        logic [63:0] m;
        int          w;
        exp_t        e;
        s = set;
        while (s != '0) begin
            m = s & pr;
            w = rr_pick((m != '0) ? m : s, mptr);
            e.id   = 6'(w);
            e.data = 8'(w + 160);
            exp_q.push_back(e);
            s[w] = 1'b0;
            mptr = w;
        end
        req = req | set;
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        n = 0;
        while (!(busy == 1'b0 && req == '0 && exp_q.size() == 0) && n < 2000) begin
            @(posedge clk);
            #1;
            out_ready = rnd ? 1'($urandom) : 1'b1;
            n++;
        end
        out_ready = 1'b1;
        if (n >= 2000) chk("idle_timeout", 64'(n), 64'd0);
    endtask

    // Requesters drop their line the cycle after being granted.
    initial begin
        logic [63:0] g;
        forever begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            if (g != '0) req = req & ~g;
        end
    end

    // Monitor: every accepted transfer pops the scoreboard; grant checked each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !rst) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", {58'd0, out_id}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_id", {58'd0, out_id}, {58'd0, e.id});
                    chk("out_data", {56'd0, out_data}, {56'd0, e.data});
                    chk("gnt_pulse", gnt, 64'd1 << e.id);
                end
            end else begin
                chk("gnt_idle", gnt, 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [63:0] orig, set;
        logic [5:0]  s_sel, s_id;
        logic [7:0]  s_data;

        rst = 1'b1; req = '0; req1 = '0; out_ready = 1'b1;
        mux_noise = 1'b0; noise = '0; prio = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sel", {58'd0, sel}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", {56'd0, out_data}, 64'd0);
        chk("rst_id", {58'd0, out_id}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_busy2", {63'd0, busy1}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single requester 0: latency 3 edges, byte A0.
        @(posedge clk); #1;
        issue(64'h1, '0);
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!out_valid && n < 20);
        chk("latency_lat0", 64'(n), 64'd3);
        chk("sel_first", {58'd0, sel}, 64'd0);
        wait_idle(1'b0);

        // Requesters 3, 17, 63: order and one transfer every three cycles.
        acc_cyc.delete();
        issue((64'h1 << 3) | (64'h1 << 17) | (64'h1 << 63), '0);
        wait_idle(1'b0);
        chk("batch_count", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            chk("throughput_a", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
            chk("throughput_b", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
        end

        // Wrap-around: pointer at 63, requesters 0 and 63.
        issue((64'h1 << 63) | 64'h1, '0);
        wait_idle(1'b0);

        // Stall in HOLD for 10 cycles with mux_out and req disturbed.
        @(posedge clk); #1;
        out_ready = 1'b0;
        orig = 64'h1 << 20;
        issue(orig, '0);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("stall_reach_hold", {63'd0, out_valid}, 64'd1);
        s_sel = sel; s_id = out_id; s_data = out_data;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            req = orig ^ {$urandom, $urandom};
            noise = 8'($urandom) | 8'h01;
            mux_noise = 1'b1;
            @(negedge clk);
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_sel", {58'd0, sel}, {58'd0, s_sel});
            chk("stall_id", {58'd0, out_id}, {58'd0, s_id});
            chk("stall_data", {56'd0, out_data}, {56'd0, s_data});
        end
        @(posedge clk); #1;
        req = orig; mux_noise = 1'b0; out_ready = 1'b1;
        wait_idle(1'b0);

        // Reset during WAIT: pointer at 20 would favour 40; after reset 5 wins.
        @(posedge clk); #1;
        req = (64'h1 << 5) | (64'h1 << 40);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_data", {56'd0, out_data}, 64'd0);
        chk("abort_id", {58'd0, out_id}, 64'd0);
        chk("abort_sel", {58'd0, sel}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_gnt", gnt, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 63;
        exp_q.delete();
        issue(req, '0);
        wait_idle(1'b0);

`ifdef MUX64_SCHED_PRIO_EN
        // Prioritised requester 40 beats 2 even though 2 is nearer the pointer.
        mptr = rr_pick(64'h1 << 63, 62);
        issue(64'h1 << 63, '0);
        wait_idle(1'b0);
        prio = 64'h1 << 40;
        issue((64'h1 << 2) | (64'h1 << 40), prio);
        wait_idle(1'b0);
`endif

        // Randomised batches with random backpressure.
        for (int it = 0; it < 25; it++) begin
            set = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if (set == '0) set = 64'h1 << $urandom_range(63, 0);
`ifdef MUX64_SCHED_PRIO_EN
            prio = {$urandom, $urandom} & {$urandom, $urandom};
`endif
            issue(set, prio);
            wait_idle(1'b1);
        end

        // Registered tree, MUX_LAT=2: capture only the settled byte, valid after 5 edges.
        @(posedge clk); #1;
        req1 = 64'h1 << 9;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!valid1 && n < 20);
        chk("latency_lat2", 64'(n), 64'd5);
        chk("lat2_data", {56'd0, data1}, 64'hA9);
        chk("lat2_id", {58'd0, id1}, 64'd9);
        chk("lat2_gnt", gnt1, 64'h1 << 9);
        @(posedge clk); #1 req1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lat2_idle", {63'd0, busy1}, 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
